// File: rtl/seg7_scan_ctrl_n_if.sv
// Display bus between the digit source and the N-digit 7-segment scan controller.
// The master drives the digit data and display controls; the slave drives the pins.
interface seg7_scan_ctrl_n_if #(
    parameter int NUM_DIGITS = 4,
    parameter int BRIGHT_W   = 3
);
    logic                    load;
    logic [5*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic [BRIGHT_W-1:0]     bright;
    logic [NUM_DIGITS-1:0]   anodo;
    logic [6:0]              seven;
    logic                    dp;
    logic                    frame_start;

    modport master (
        output load, digits_in, dp_in, digit_en, blink_mask, bright,
        input  anodo, seven, dp, frame_start
    );

    modport slave (
        input  load, digits_in, dp_in, digit_en, blink_mask, bright,
        output anodo, seven, dp, frame_start
    );
endinterface

// File: rtl/seg7_scan_ctrl_n.sv
// N-digit multiplexed 7-segment scan controller with frame-synchronous loading,
// PWM brightness, per-digit enable/blink and decimal points.
module seg7_scan_ctrl_n #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 27000,
    parameter int BRIGHT_W       = 3,
    parameter int BLINK_FRAMES   = 64,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    seg7_scan_ctrl_n_if.slave bus
);
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int OL_W  = CNT_W + BRIGHT_W + 1;

    localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = (SEG_ACTIVE_LOW != 0);

    logic [CNT_W-1:0]            r_cnt;
    logic [SEL_W-1:0]            r_sel;
    logic [BLK_W-1:0]            r_blink_cnt;
    logic                        r_blink_on;
    logic [NUM_DIGITS-1:0][4:0]  r_sh_code;
    logic [NUM_DIGITS-1:0][4:0]  r_act_code;
    logic [NUM_DIGITS-1:0]       r_sh_dp;
    logic [NUM_DIGITS-1:0]       r_act_dp;
    logic                        r_pending;
    logic [NUM_DIGITS-1:0]       r_anodo;
    logic [6:0]                  r_seven;
    logic                        r_dp;
    logic                        r_frame_end_d;
    logic                        r_frame_start;

    logic                        w_tick;
    logic                        w_frame_end;
    logic [OL_W-1:0]             w_on_len;
    logic [4:0]                  w_code;
    logic                        w_lit;
    logic [6:0]                  w_glyph;
    logic [NUM_DIGITS-1:0]       w_anodo;

    assign w_tick      = (r_cnt == CNT_W'(REFRESH_DIV - 1));
    assign w_frame_end = w_tick && (r_sel == SEL_W'(NUM_DIGITS - 1));

    // Worst case product is 2^BRIGHT_W * REFRESH_DIV, which fits in OL_W bits.
    assign w_on_len = ((OL_W'(bus.bright) + OL_W'(1)) * OL_W'(REFRESH_DIV)) >> BRIGHT_W;

    assign w_code = r_act_code[r_sel];
    assign w_lit  = bus.digit_en[r_sel] && (OL_W'(r_cnt) < w_on_len)
                    && !(bus.blink_mask[r_sel] && !r_blink_on);

    always_comb begin
        w_glyph = 7'h00;
        case (w_code)
            5'h00: w_glyph = 7'h3F;
            5'h01: w_glyph = 7'h06;
            5'h02: w_glyph = 7'h5B;
            5'h03: w_glyph = 7'h4F;
            5'h04: w_glyph = 7'h66;
            5'h05: w_glyph = 7'h6D;
            5'h06: w_glyph = 7'h7D;
            5'h07: w_glyph = 7'h07;
            5'h08: w_glyph = 7'h7F;
            5'h09: w_glyph = 7'h6F;
            5'h0A: w_glyph = 7'h77;
            5'h0B: w_glyph = 7'h7C;
            5'h0C: w_glyph = 7'h39;
            5'h0D: w_glyph = 7'h5E;
            5'h0E: w_glyph = 7'h79;
            5'h0F: w_glyph = 7'h71;
            5'h10: w_glyph = 7'h40;
            default: w_glyph = 7'h00;
        endcase
    end

    always_comb begin
        w_anodo = '1;
        if (w_lit) w_anodo[r_sel] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_sel <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
            r_sel <= (r_sel == SEL_W'(NUM_DIGITS - 1)) ? '0 : r_sel + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (w_frame_end) begin
            if (r_blink_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
                r_blink_cnt <= '0;
                r_blink_on  <= ~r_blink_on;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    // Active codes only change on the frame boundary so a frame never shows a mix.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_code  <= {NUM_DIGITS{5'h1F}};
            r_act_code <= {NUM_DIGITS{5'h1F}};
            r_sh_dp    <= '0;
            r_act_dp   <= '0;
            r_pending  <= 1'b0;
        end else if (bus.load) begin
            r_sh_code <= bus.digits_in;
            r_sh_dp   <= bus.dp_in;
            if (w_frame_end) begin
                r_act_code <= bus.digits_in;
                r_act_dp   <= bus.dp_in;
                r_pending  <= 1'b0;
            end else begin
                r_pending <= 1'b1;
            end
        end else if (w_frame_end && r_pending) begin
            r_act_code <= r_sh_code;
            r_act_dp   <= r_sh_dp;
            r_pending  <= 1'b0;
        end
    end

    // frame_start is delayed twice so it coincides with digit 0 appearing on the pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_anodo       <= '1;
            r_seven       <= SEG_OFF;
            r_dp          <= DP_OFF;
            r_frame_end_d <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_anodo       <= w_anodo;
            r_seven       <= (w_lit ? w_glyph : 7'h00) ^ SEG_OFF;
            r_dp          <= (w_lit & r_act_dp[r_sel]) ^ DP_OFF;
            r_frame_end_d <= w_frame_end;
            r_frame_start <= r_frame_end_d;
        end
    end

    assign bus.anodo       = r_anodo;
    assign bus.seven       = r_seven;
    assign bus.dp          = r_dp;
    assign bus.frame_start = r_frame_start;
endmodule
